al422_spi_frame_writer: RTL

Write-side front end for the AL422 frame FIFO. It receives a frame of pixel bytes from the host MCU over SPI (mode 0, MSB first) and writes them into the AL422 write port. It pulses the AL422 write reset at each frame start, counts bytes, and flags short, long and overrun frames. The LED scan engine drains the same FIFO on the read side.

---
 rtl/al422_pkg.sv | 9 +
 rtl/spi_byte_rx.sv | 59 +++++
 rtl/al422_spi_frame_writer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/al422_pkg.sv
// al422_pkg: frame geometry and write-FSM encoding shared by the AL422 write front end.
package al422_pkg;
  localparam int PIXEL_COUNT     = 64;
  localparam int ROWS            = 8;
  localparam int RGB_OUTPUTS     = 2;
  localparam int BYTES_PER_PIXEL = 2;
  localparam int FRAME_BYTES_DEF = PIXEL_COUNT * ROWS * RGB_OUTPUTS * BYTES_PER_PIXEL;
  typedef enum logic [2:0] {IDLE, WRST, SETUP, STROBE, HOLD} wr_state_e;
endpackage

// File: rtl/spi_byte_rx.sv
// spi_byte_rx: synchronizes SPI mode-0 inputs into clk_i and assembles MSB-first bytes.
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       sclk_i,
  input  logic       mosi_i,
  input  logic       cs_n_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       cs_fall_o,
  output logic       cs_rise_o
);
  logic [SYNC_STAGES-1:0] sclk_sq, mosi_sq, cs_sq;
  logic                   sclk_last_q, cs_last_q, byte_valid_q;
  logic [2:0]             bit_cnt_q;
  logic [6:0]             shift_q;
  logic [7:0]             byte_q;
  logic                   sclk_s, mosi_s, cs_s, sclk_rise;
  assign sclk_s       = sclk_sq[SYNC_STAGES-1];
  assign mosi_s       = mosi_sq[SYNC_STAGES-1];
  assign cs_s         = cs_sq[SYNC_STAGES-1];
  assign sclk_rise    = sclk_s & ~sclk_last_q;
  assign cs_fall_o    = ~cs_s & cs_last_q;
  assign cs_rise_o    = cs_s & ~cs_last_q;
  assign byte_valid_o = byte_valid_q;
  assign byte_o       = byte_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_sq      <= '0;
      mosi_sq      <= '0;
      cs_sq        <= '1;
      sclk_last_q  <= 1'b0;
      cs_last_q    <= 1'b1;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      sclk_sq      <= {sclk_sq[SYNC_STAGES-2:0], sclk_i};
      mosi_sq      <= {mosi_sq[SYNC_STAGES-2:0], mosi_i};
      cs_sq        <= {cs_sq[SYNC_STAGES-2:0], cs_n_i};
      sclk_last_q  <= sclk_s;
      cs_last_q    <= cs_s;
      byte_valid_q <= 1'b0;
      // Either select edge drops any partial byte.
      if (cs_fall_o || cs_rise_o) bit_cnt_q <= '0;
      else if (!cs_s && sclk_rise) begin
        shift_q   <= {shift_q[5:0], mosi_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_valid_q <= 1'b1;
          byte_q       <= {shift_q, mosi_s};
        end
      end
    end
  end
endmodule

// File: rtl/al422_spi_frame_writer.sv
// al422_spi_frame_writer: writes SPI-received frame bytes into the AL422 write port
// with a write-pointer reset per frame and short/long/overrun frame flags.
module al422_spi_frame_writer
  import al422_pkg::*;
#(
  parameter int FRAME_BYTES = FRAME_BYTES_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int WRST_CYCLES = 4,
  parameter int CNT_W       = $clog2(FRAME_BYTES + 1)
) (
  input  logic       in_clk,
  input  logic       in_nrst,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  output logic [7:0] al422_data,
  output logic       al422_wck,
  output logic       al422_nwe,
  output logic       al422_nwrst,
  output logic       frame_done,
  output logic       err_short,
  output logic       err_long,
  output logic       err_overrun
);
  localparam int WW = $clog2(WRST_CYCLES) + 1;
  wr_state_e        state_q;
  logic [WW-1:0]    wrst_cnt_q;
  logic [CNT_W-1:0] byte_cnt_q;
  logic [7:0]       hold_q, data_q;
  logic             hold_valid_q, wck_q, nwe_q, nwrst_q, frame_done_q;
  logic             err_short_q, err_long_q, err_overrun_q;
  logic             byte_valid, cs_fall, cs_rise, full;
  logic [7:0]       rx_byte;
  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk_i        (in_clk),
    .rst_ni       (in_nrst),
    .sclk_i       (spi_sclk),
    .mosi_i       (spi_mosi),
    .cs_n_i       (spi_cs_n),
    .byte_valid_o (byte_valid),
    .byte_o       (rx_byte),
    .cs_fall_o    (cs_fall),
    .cs_rise_o    (cs_rise)
  );
  assign full        = byte_cnt_q == CNT_W'(FRAME_BYTES);
  assign al422_data  = data_q;
  assign al422_wck   = wck_q;
  assign al422_nwe   = nwe_q;
  assign al422_nwrst = nwrst_q;
  assign frame_done  = frame_done_q;
  assign err_short   = err_short_q;
  assign err_long    = err_long_q;
  assign err_overrun = err_overrun_q;
  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      state_q       <= IDLE;
      wrst_cnt_q    <= '0;
      byte_cnt_q    <= '0;
      hold_q        <= '0;
      hold_valid_q  <= 1'b0;
      data_q        <= '0;
      wck_q         <= 1'b0;
      nwe_q         <= 1'b1;
      nwrst_q       <= 1'b1;
      frame_done_q  <= 1'b0;
      err_short_q   <= 1'b0;
      err_long_q    <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (cs_fall) begin
        state_q       <= WRST;
        wrst_cnt_q    <= WW'(WRST_CYCLES - 1);
        nwrst_q       <= 1'b0;
        nwe_q         <= 1'b1;
        wck_q         <= 1'b0;
        hold_valid_q  <= 1'b0;
        byte_cnt_q    <= '0;
        err_short_q   <= 1'b0;
        err_long_q    <= 1'b0;
        err_overrun_q <= 1'b0;
      end else begin
        // A byte still waiting in the holding register counts toward the frame.
        if (cs_rise && (byte_cnt_q + CNT_W'(hold_valid_q)) < CNT_W'(FRAME_BYTES)) err_short_q <= 1'b1;
        case (state_q)
          IDLE: if (hold_valid_q) begin
            state_q <= SETUP;
            data_q  <= hold_q;
            nwe_q   <= 1'b0;
          end
          WRST: if (wrst_cnt_q == '0) begin
            state_q <= IDLE;
            nwrst_q <= 1'b1;
          end else wrst_cnt_q <= wrst_cnt_q - WW'(1);
          SETUP: begin
            state_q <= STROBE;
            wck_q   <= 1'b1;
          end
          STROBE: begin
            state_q <= HOLD;
            wck_q   <= 1'b0;
            nwe_q   <= 1'b1;
          end
          HOLD: begin
            state_q      <= IDLE;
            hold_valid_q <= 1'b0;
            byte_cnt_q   <= byte_cnt_q + CNT_W'(1);
            frame_done_q <= (byte_cnt_q + CNT_W'(1)) == CNT_W'(FRAME_BYTES);
          end
          default: state_q <= IDLE;
        endcase
        if (byte_valid) begin
          if (full) err_long_q <= 1'b1;
          else if (hold_valid_q) err_overrun_q <= 1'b1;
          else begin
            hold_valid_q <= 1'b1;
            hold_q       <= rx_byte;
          end
        end
      end
    end
  end
endmodule
